// File: rtl/knn_pkg.sv
// Shared widths, sizes and the job-sequencer state type for the KNN host driver.
package knn_pkg;
  localparam int unsigned X_W         = 11;
  localparam int unsigned Y_W         = 10;
  localparam int unsigned PT_W        = X_W + Y_W;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned DEPTH       = 1 << ADDR_W;
  localparam int unsigned N_TRAIN_DEF = 128;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    UPDATE,
    TRAIN,
    QUERY,
    WAIT_RES
  } state_e;
endpackage

// File: rtl/knn_host_driver_if.sv
// Chip-side point/result bus between the host driver (master) and the KNN chip (slave).
interface knn_host_driver_if;
  import knn_pkg::*;

  logic [X_W-1:0] o_x;
  logic [Y_W-1:0] o_y;
  logic           o_valid;
  logic           o_data_type;
  logic           o_train_points_update;
  logic           i_valid;
  logic           i_group;
  logic           i_busy;

  modport master (
    output o_x, o_y, o_valid, o_data_type, o_train_points_update,
    input  i_valid, i_group, i_busy
  );

  modport slave (
    input  o_x, o_y, o_valid, o_data_type, o_train_points_update,
    output i_valid, i_group, i_busy
  );
endinterface

// File: rtl/knn_point_ram.sv
// 128x21 training-point buffer: one write port, one registered read port.
module knn_point_ram
  import knn_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PT_W-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PT_W-1:0]   rdata
);
  logic [PT_W-1:0] mem_q [DEPTH];
  logic [PT_W-1:0] rdata_q;

  // Same-address read and write in one cycle returns the old entry.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/knn_host_driver.sv
// Host-side job sequencer: streams the training buffer and a query to the KNN chip
// and returns the classification result (or a timeout) to the host.
module knn_host_driver
  import knn_pkg::*;
#(
  parameter int unsigned N_TRAIN    = N_TRAIN_DEF,
  parameter int unsigned UPD_CYCLES = 35,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_wr_en,
  input  logic [ADDR_W-1:0] h_wr_addr,
  input  logic [X_W-1:0]    h_wr_x,
  input  logic [Y_W-1:0]    h_wr_y,
  input  logic [X_W-1:0]    h_q_x,
  input  logic [Y_W-1:0]    h_q_y,
  input  logic              h_start,
  input  logic              h_update,
  knn_host_driver_if.master chip,
  output logic              o_res_valid,
  output logic              o_res_group,
  output logic              o_job_busy,
  output logic              o_timeout
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   qx_q, qx_d, pt_x_q, pt_x_d;
  logic [Y_W-1:0]   qy_q, qy_d, pt_y_q, pt_y_d;
  logic             upd_q, upd_d;
  logic             trn_vld_q, trn_vld_d;
  logic             res_valid_q, res_valid_d;
  logic             res_group_q, res_group_d;
  logic             timeout_q, timeout_d;
  logic [PT_W-1:0]  rd_data;
  logic             qry_vld;

  // The shared counter doubles as the read address, one cycle ahead of the stream.
  knn_point_ram u_ram (
    .clk   (clk),
    .we    (h_wr_en),
    .waddr (h_wr_addr),
    .wdata ({h_wr_x, h_wr_y}),
    .raddr (cnt_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    qx_d        = qx_q;
    qy_d        = qy_q;
    upd_d       = upd_q;
    trn_vld_d   = 1'b0;
    res_valid_d = 1'b0;
    res_group_d = res_group_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (h_start) begin
          qx_d      = h_q_x;
          qy_d      = h_q_y;
          upd_d     = h_update;
          timeout_d = 1'b0;
          state_d   = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        cnt_d = '0;
        if (!chip.i_busy) state_d = upd_q ? UPDATE : TRAIN;
      end
      UPDATE: begin
        if (cnt_q == CNT_W'(UPD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = TRAIN;
        end
      end
      TRAIN: begin
        trn_vld_d = (cnt_q < CNT_W'(N_TRAIN));
        if (cnt_q == CNT_W'(N_TRAIN)) begin
          cnt_d   = '0;
          state_d = QUERY;
        end
      end
      QUERY: begin
        cnt_d   = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (chip.i_valid) begin
          res_valid_d = 1'b1;
          res_group_d = chip.i_group;
          state_d     = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Point outputs: RAM data while streaming, query in QUERY, otherwise hold.
  always_comb begin
    qry_vld = (state_q == QUERY);
    pt_x_d  = pt_x_q;
    pt_y_d  = pt_y_q;
    if (trn_vld_q) begin
      pt_x_d = rd_data[PT_W-1:Y_W];
      pt_y_d = rd_data[Y_W-1:0];
    end else if (qry_vld) begin
      pt_x_d = qx_q;
      pt_y_d = qy_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      qx_q        <= '0;
      qy_q        <= '0;
      upd_q       <= 1'b0;
      trn_vld_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_group_q <= 1'b0;
      timeout_q   <= 1'b0;
      pt_x_q      <= '0;
      pt_y_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      qx_q        <= qx_d;
      qy_q        <= qy_d;
      upd_q       <= upd_d;
      trn_vld_q   <= trn_vld_d;
      res_valid_q <= res_valid_d;
      res_group_q <= res_group_d;
      timeout_q   <= timeout_d;
      pt_x_q      <= pt_x_d;
      pt_y_q      <= pt_y_d;
    end
  end

  assign chip.o_x                   = pt_x_d;
  assign chip.o_y                   = pt_y_d;
  assign chip.o_valid               = trn_vld_q | qry_vld;
  assign chip.o_data_type           = qry_vld;
  assign chip.o_train_points_update = (state_q == UPDATE);
  assign o_res_valid                = res_valid_q;
  assign o_res_group                = res_group_q;
  assign o_job_busy                 = (state_q != IDLE);
  assign o_timeout                  = timeout_q;
endmodule

// File: tb/tb_knn_host_driver.sv
// Directed job sequence with randomized buffer contents, writes and chip timing,
// checked cycle by cycle against a job-level model of the host driver.
module tb_knn_host_driver;
  localparam int unsigned N   = 128;
  localparam int unsigned UPD = 35;
  localparam int unsigned TMO = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_wr_en;
  logic [6:0]  h_wr_addr;
  logic [10:0] h_wr_x, h_q_x;
  logic [9:0]  h_wr_y, h_q_y;
  logic        h_start, h_update;
  logic        o_res_valid, o_res_group, o_job_busy, o_timeout;

  knn_host_driver_if chip ();

  knn_host_driver #(
    .N_TRAIN    (N),
    .UPD_CYCLES (UPD),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .h_wr_en     (h_wr_en),
    .h_wr_addr   (h_wr_addr),
    .h_wr_x      (h_wr_x),
    .h_wr_y      (h_wr_y),
    .h_q_x       (h_q_x),
    .h_q_y       (h_q_y),
    .h_start     (h_start),
    .h_update    (h_update),
    .chip        (chip),
    .o_res_valid (o_res_valid),
    .o_res_group (o_res_group),
    .o_job_busy  (o_job_busy),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: buffer contents and the last point value the chip bus showed.
  logic [10:0] ref_x [N];
  logic [9:0]  ref_y [N];
  logic [10:0] last_x;
  logic [9:0]  last_y;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_cycle(input string tag, input logic upd, input logic v, input logic t,
                              input logic [10:0] x, input logic [9:0] y,
                              input logic rv, input logic busy);
    if (v) begin
      last_x = x;
      last_y = y;
    end
    check(tag,
          32'({chip.o_train_points_update, chip.o_valid, chip.o_data_type,
               chip.o_x, chip.o_y, o_res_valid, o_job_busy}),
          32'({upd, v, t, last_x, last_y, rv, busy}));
  endtask

  task automatic load(input int unsigned a, input logic [10:0] x, input logic [9:0] y);
    h_wr_en   = 1'b1;
    h_wr_addr = 7'(a);
    h_wr_x    = x;
    h_wr_y    = y;
    ref_x[a]  = x;
    ref_y[a]  = y;
    tick();
    h_wr_en = 1'b0;
  endtask

  // Launch a job and follow it to the end of QUERY (or to a reset at point rst_at).
  task automatic run_job(input bit upd, input int unsigned busy, input logic [10:0] qx,
                         input logic [9:0] qy, input bit noisy, input int rst_at);
    int unsigned u, total, lim;
    int idx, a;
    u     = upd ? UPD : 0;
    total = u + N + 2;
    h_start     = 1'b1;
    h_update    = upd;
    h_q_x       = qx;
    h_q_y       = qy;
    chip.i_busy = (busy != 0);
    tick();
    h_start  = 1'b0;
    h_q_x    = 11'($urandom);
    h_q_y    = 10'($urandom);
    h_update = 1'($urandom);
    check("start_clears_timeout", 32'(o_timeout), 32'd0);
    lim = (busy == 0) ? 1 : busy;
    for (int unsigned b = 0; b < lim; b++) begin
      expect_cycle("wait_rdy", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      if (b + 1 >= busy) chip.i_busy = 1'b0;
      tick();
    end
    for (int unsigned k = 1; k <= total; k++) begin
      h_wr_en      = 1'b0;
      h_start      = 1'b0;
      chip.i_valid = 1'b0;
      if (k <= u) begin
        expect_cycle("update_phase", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      end else if (k == u + 1) begin
        expect_cycle("train_bubble", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      end else if (k < total) begin
        idx = int'(k - u - 2);
        expect_cycle($sformatf("train_pt_%0d", idx), 1'b0, 1'b1, 1'b0,
                     ref_x[idx], ref_y[idx], 1'b0, 1'b1);
        if (idx == rst_at) begin
          rst = 1'b1;
          tick();
          last_x = '0;
          last_y = '0;
          expect_cycle("abort_reset", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
          check("abort_timeout", 32'(o_timeout), 32'd0);
          rst = 1'b0;
          tick();
          expect_cycle("abort_idle", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
          return;
        end
        if (noisy) begin
          a = int'($urandom_range(N - 1, 0));
          if ($urandom_range(2, 0) == 0 && a != idx + 1) begin
            h_wr_en   = 1'b1;
            h_wr_addr = 7'(a);
            h_wr_x    = 11'($urandom);
            h_wr_y    = 10'($urandom);
            ref_x[a]  = h_wr_x;
            ref_y[a]  = h_wr_y;
          end
          chip.i_valid = ($urandom_range(3, 0) == 0);
          chip.i_group = 1'($urandom);
          h_start      = ($urandom_range(7, 0) == 0);
          h_q_x        = 11'($urandom);
          h_q_y        = 10'($urandom);
          h_update     = 1'($urandom);
        end
      end else begin
        expect_cycle("query_pt", 1'b0, 1'b1, 1'b1, qx, qy, 1'b0, 1'b1);
      end
      tick();
    end
    h_wr_en      = 1'b0;
    h_start      = 1'b0;
    chip.i_valid = 1'b0;
  endtask

  // Called one cycle after QUERY; i_valid is raised delay cycles after QUERY.
  task automatic get_result(input int unsigned delay, input logic grp);
    for (int unsigned d = 1; d < delay; d++) begin
      expect_cycle("wait_res", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      tick();
    end
    expect_cycle("wait_res_last", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chip.i_valid = 1'b1;
    chip.i_group = grp;
    tick();
    chip.i_valid = 1'b0;
    chip.i_group = ~grp;
    expect_cycle("res_pulse", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("res_group", 32'(o_res_group), 32'(grp));
    check("res_no_timeout", 32'(o_timeout), 32'd0);
    tick();
    expect_cycle("res_done", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic expect_timeout();
    int unsigned rv_seen;
    rv_seen = 0;
    for (int unsigned j = 1; j < TMO; j++) begin
      if (o_res_valid) rv_seen++;
      tick();
    end
    expect_cycle("tmo_last_wait", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("tmo_not_yet", 32'(o_timeout), 32'd0);
    tick();
    expect_cycle("tmo_idle", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("tmo_flag", 32'(o_timeout), 32'd1);
    check("tmo_no_result", rv_seen, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    h_wr_en      = 1'b0;
    h_wr_addr    = '0;
    h_wr_x       = '0;
    h_wr_y       = '0;
    h_q_x        = '0;
    h_q_y        = '0;
    h_start      = 1'b0;
    h_update     = 1'b0;
    chip.i_valid = 1'b0;
    chip.i_group = 1'b0;
    chip.i_busy  = 1'b0;
    last_x       = '0;
    last_y       = '0;
    repeat (3) tick();
    expect_cycle("reset_outputs", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("reset_timeout", 32'(o_timeout), 32'd0);
    check("reset_group", 32'(o_res_group), 32'd0);
    rst = 1'b0;
    tick();
    expect_cycle("idle_after_reset", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Identity buffer, fixed query, classification 10 cycles after QUERY.
    for (int unsigned i = 0; i < N; i++) load(i, 11'(i), 10'(i));
    run_job(1'b0, 0, 11'd1010, 10'd1010, 1'b0, -1);
    get_result(10, 1'b1);

    // Random buffer with the update phase first.
    for (int unsigned i = 0; i < N; i++) load(i, 11'($urandom), 10'($urandom));
    run_job(1'b1, 0, 11'($urandom), 10'($urandom), 1'b0, -1);
    get_result($urandom_range(20, 1), 1'($urandom));

    // Chip busy at start, writes/strays during the stream, no result.
    run_job(1'b0, 50, 11'($urandom), 10'($urandom), 1'b1, -1);
    expect_timeout();
    repeat (4) tick();
    check("timeout_sticky", 32'(o_timeout), 32'd1);

    // Reset mid-stream, then a fresh job from entry 0 with the same buffer.
    run_job(1'b0, 0, 11'($urandom), 10'($urandom), 1'b0, 60);
    run_job(1'b1, 3, 11'($urandom), 10'($urandom), 1'b1, -1);
    get_result($urandom_range(30, 1), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/knn_host_driver.md
KNN_HOST_DRIVER -- requirements
Module: knn_host_driver

Interface
REQ-001 Parameter N_TRAIN, default 128: number of training points streamed per job.
REQ-002 Parameter UPD_CYCLES, default 35: cycles o_train_points_update is held high.
REQ-003 Parameter TIMEOUT, default 1023: maximum cycles waited for a classification result.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 h_wr_en  in  1  host write strobe into the training buffer.
REQ-007 h_wr_addr  in  7  training buffer address.
REQ-008 h_wr_x / h_wr_y  in  11 / 10  training point coordinates.
REQ-009 h_q_x / h_q_y  in  11 / 10  query point, sampled on h_start.
REQ-010 h_start  in  1  one-cycle pulse that launches a job.
REQ-011 h_update  in  1  sampled with h_start; 1 = run the train-points-update phase first.
REQ-012 o_x / o_y  out  11 / 10  point coordinates driven to the chip.
REQ-013 o_valid, o_data_type  out  1 each  chip point strobe; type 0 = train, 1 = test.
REQ-014 o_train_points_update  out  1  chip update request.
REQ-015 i_valid, i_group, i_busy  in  1 each  chip result strobe, class, busy flag.
REQ-016 o_res_valid, o_res_group  out  1 each  one-cycle result to host.
REQ-017 o_job_busy, o_timeout  out  1 each  job in progress; sticky timeout flag.

Function
REQ-018 FSM states: IDLE, WAIT_RDY, UPDATE, TRAIN, QUERY, WAIT_RES.
REQ-019 IDLE: h_start captures h_q_x, h_q_y, h_update, clears o_timeout, next WAIT_RDY; h_start outside IDLE is ignored.
REQ-020 WAIT_RDY: stay while i_busy=1; when i_busy=0, go to UPDATE if the captured update bit is 1, else TRAIN.
REQ-021 UPDATE: o_train_points_update=1 for exactly UPD_CYCLES cycles, o_valid=0, then TRAIN.
REQ-022 TRAIN: buffer entries 0..N_TRAIN-1 are driven in ascending order, one per cycle, o_valid=1, o_data_type=0, no gaps; the first point appears the cycle after entering TRAIN.
REQ-023 QUERY: one cycle with o_valid=1, o_data_type=1, o_x/o_y = captured query; then WAIT_RES.
REQ-024 WAIT_RES: i_valid=1 gives o_res_valid=1 and o_res_group=i_group the next cycle, then IDLE.
REQ-025 WAIT_RES timeout: TIMEOUT cycles without i_valid sets o_timeout=1, returns to IDLE, and emits no o_res_valid.
REQ-026 i_valid outside WAIT_RES is ignored.
REQ-027 o_x/o_y hold their last value when o_valid=0; o_data_type=0 whenever o_valid=0.
REQ-028 o_job_busy=1 in every state except IDLE.
REQ-029 A buffer write (h_wr_en) is accepted in any state; a write to an address during TRAIN becomes visible only if that address has not yet been read.
REQ-030 Buffer read latency is one cycle; the address counter leads the output by one cycle so the TRAIN stream has no bubbles.
REQ-031 Job length without update: 1 + N_TRAIN + 1 cycles from leaving WAIT_RDY to the end of QUERY.

Reset
REQ-032 rst=1 forces IDLE and drives o_valid, o_data_type, o_train_points_update, o_res_valid, o_res_group, o_job_busy, and o_timeout to 0, with o_x=0 and o_y=0.
REQ-033 rst mid-job aborts the job with no further chip strobes; buffer contents are not cleared.

Structure
REQ-034 Package knn_pkg holds X_W=11, Y_W=10, N_TRAIN default, and the state enum.
REQ-035 Sub-module knn_point_ram is a 128x21 single-write, single-read synchronous RAM.

Verification
REQ-036 Load entry i with (i,i) for i=0..127, h_start with query (1010,1010), update=0, i_busy=0 -> 128 consecutive o_valid type-0 points 0..127, then one type-1 point (1010,1010).
REQ-037 h_start with update=1 -> o_train_points_update high exactly 35 cycles, o_valid=0 throughout, then the stream per REQ-036.
REQ-038 i_busy=1 for 50 cycles at h_start -> no o_valid until the cycle after i_busy falls.
REQ-039 i_valid=1 with i_group=1, 10 cycles after QUERY -> o_res_valid pulse with group 1, then o_job_busy=0.
REQ-040 No i_valid after QUERY -> o_timeout=1 after 1023 cycles, IDLE, no o_res_valid.
REQ-041 rst asserted at TRAIN point 60 -> o_valid=0 the next cycle; a new job restarts from entry 0.
